// File: rtl/dmux_stream.sv
// Registered 1:WAYS stream demultiplexer behind a 2-entry FIFO, valid/ready on both sides.
// Optional per-channel delivered-word counters are enabled by defining DMUX_STREAM_COUNT_EN.
module dmux_stream_lane #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 2,
  parameter int IDX   = 0
) (
  input  logic             head_vld,
  input  logic [SEL_W-1:0] head_sel,
  input  logic [WIDTH-1:0] head_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);
  assign valid = head_vld && (head_sel == SEL_W'(IDX));
  assign data  = valid ? head_data : '0;
endmodule

module dmux_stream #(
  parameter int WIDTH = 16,
  parameter int WAYS  = 4,
  parameter int SEL_W = 2,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [SEL_W-1:0]      in_sel,
  output logic [WAYS-1:0]       out_valid,
  input  logic [WAYS-1:0]       out_ready,
  output logic [WAYS*WIDTH-1:0] out_data,
  output logic                  drop
`ifdef DMUX_STREAM_COUNT_EN
  ,
  input  logic                  count_clr,
  output logic [WAYS*CNT_W-1:0] count
`endif
);
  if (WAYS < 2 || (1 << SEL_W) < WAYS || CNT_W < 1) begin : g_bad_cfg
    $error("dmux_stream: illegal WAYS/SEL_W/CNT_W combination");
  end

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] data;
  } entry_t;

  entry_t     mem_q [2];
  logic [1:0] occ_q;
  logic       wp_q, rp_q, drop_q;

  entry_t                      head;
  logic                        head_vld, sel_ok, accept, push, pop;
  logic [WAYS-1:0]             lane_vld;
  logic [WAYS-1:0][WIDTH-1:0]  lane_data;

  // Extra top bit keeps the compare correct when WAYS == 2**SEL_W.
  assign sel_ok   = {1'b0, in_sel} < (SEL_W+1)'(WAYS);
  assign in_ready = (occ_q != 2'd2);
  assign accept   = in_valid & in_ready;
  assign push     = accept & sel_ok;
  assign head     = mem_q[rp_q];
  assign head_vld = (occ_q != 2'd0);
  assign pop      = |(lane_vld & out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      occ_q    <= '0;
      wp_q     <= 1'b0;
      rp_q     <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wp_q] <= '{sel: in_sel, data: in_data};
        wp_q        <= ~wp_q;
      end
      if (pop) rp_q <= ~rp_q;
      occ_q  <= occ_q + 2'(push) - 2'(pop);
      drop_q <= accept & ~sel_ok;
    end
  end

  for (genvar k = 0; k < WAYS; k++) begin : g_lane
    dmux_stream_lane #(.WIDTH(WIDTH), .SEL_W(SEL_W), .IDX(k)) u_lane (
      .head_vld  (head_vld),
      .head_sel  (head.sel),
      .head_data (head.data),
      .valid     (lane_vld[k]),
      .data      (lane_data[k])
    );
  end

  assign out_valid = lane_vld;
  assign out_data  = lane_data;
  assign drop      = drop_q;

`ifdef DMUX_STREAM_COUNT_EN
  logic [WAYS-1:0][CNT_W-1:0] cnt_q;

  // Clear has priority over a coinciding pop; counters stick at all-ones.
  for (genvar k = 0; k < WAYS; k++) begin : g_cnt
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                            cnt_q[k] <= '0;
      else if (count_clr)                                    cnt_q[k] <= '0;
      else if (lane_vld[k] && out_ready[k] && cnt_q[k] != '1) cnt_q[k] <= cnt_q[k] + 1'b1;
    end
  end

  assign count = cnt_q;
`endif
endmodule

// File: tb/tb_dmux_stream.sv
// Directed bench for dmux_stream: scoreboard queue of accepted words checked against
// the channel outputs every cycle, plus a WAYS=3 instance for the discard path.
module tb_dmux_stream;
  localparam int W    = 16;
  localparam int WAYS = 4;
  localparam int SW   = 2;
  localparam int CW   = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic              in_valid, in_ready, drop;
  logic [W-1:0]      in_data;
  logic [SW-1:0]     in_sel;
  logic [WAYS-1:0]   out_valid, out_ready;
  logic [WAYS*W-1:0] out_data;
`ifdef DMUX_STREAM_COUNT_EN
  logic              count_clr;
  logic [WAYS*CW-1:0] count;
  logic [WAYS-1:0][CW-1:0] mcnt;
`endif

  logic           b_in_valid, b_in_ready, b_drop;
  logic [W-1:0]   b_in_data;
  logic [SW-1:0]  b_in_sel;
  logic [2:0]     b_out_valid, b_out_ready;
  logic [3*W-1:0] b_out_data;
`ifdef DMUX_STREAM_COUNT_EN
  logic           b_count_clr;
  logic [3*CW-1:0] b_count;
`endif

  dmux_stream #(.WIDTH(W), .WAYS(WAYS), .SEL_W(SW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .drop(drop)
`ifdef DMUX_STREAM_COUNT_EN
    , .count_clr(count_clr), .count(count)
`endif
  );

  dmux_stream #(.WIDTH(W), .WAYS(3), .SEL_W(SW), .CNT_W(CW)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_sel(b_in_sel), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .drop(b_drop)
`ifdef DMUX_STREAM_COUNT_EN
    , .count_clr(b_count_clr), .count(b_count)
`endif
  );

  typedef struct packed {
    logic [SW-1:0] sel;
    logic [W-1:0]  data;
  } word_t;

  word_t sb[$];
  int    n_chk  = 0;
  int    n_fail = 0;
  logic  accepted;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs against the scoreboard head, then advance the model at the edge.
  task automatic tick();
    logic [WAYS-1:0]   ev;
    logic [WAYS*W-1:0] ed;
    bit pop, acc;
    @(negedge clk);
    ev = '0;
    ed = '0;
    if (sb.size() > 0) begin
      ev[sb[0].sel] = 1'b1;
      ed[sb[0].sel*W +: W] = sb[0].data;
    end
    chk("out_valid", 64'(out_valid), 64'(ev));
    chk("out_data",  64'(out_data),  64'(ed));
    chk("in_ready",  64'(in_ready),  64'(sb.size() < 2));
    chk("drop",      64'(drop),      64'd0);
`ifdef DMUX_STREAM_COUNT_EN
    chk("count", 64'(count), 64'(mcnt));
`endif
    pop = (sb.size() > 0) && out_ready[sb[0].sel];
    acc = in_valid && (sb.size() < 2);
    @(posedge clk);
`ifdef DMUX_STREAM_COUNT_EN
    if (count_clr) mcnt = '0;
    else if (pop && mcnt[sb[0].sel] != 2'd3) mcnt[sb[0].sel] = mcnt[sb[0].sel] + 2'd1;
`endif
    if (pop) void'(sb.pop_front());
    if (acc) sb.push_back('{sel: in_sel, data: in_data});
    accepted = acc;
    #1;
  endtask

  task automatic drive(input logic v, input logic [SW-1:0] s, input logic [W-1:0] d);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
  endtask

  task automatic drain();
    int n;
    in_valid  = 1'b0;
    out_ready = '1;
    n = 0;
    while (sb.size() > 0 && n < 10) begin
      tick();
      n++;
    end
    chk("drain_done", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    drive(1'b0, '0, '0);
    out_ready = '0;
    b_in_valid = 1'b0; b_in_sel = '0; b_in_data = '0; b_out_ready = '0;
`ifdef DMUX_STREAM_COUNT_EN
    count_clr = 1'b0; b_count_clr = 1'b0; mcnt = '0;
`endif
    #3;
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_drop",      64'(drop),      64'd0);
`ifdef DMUX_STREAM_COUNT_EN
    chk("rst_count", 64'(count), 64'd0);
`endif
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single word to channel 2, held by a stalled consumer
    drive(1'b1, 2'd2, 16'hA5A5);
    tick();
    drive(1'b0, '0, '0);
    tick();
    chk("w2_valid", 64'(out_valid), 64'h4);
    chk("w2_slice", 64'(out_data[2*W +: W]), 64'hA5A5);
    tick();
    out_ready = 4'h4;
    tick();
    out_ready = '0;
    tick();

    // Fill to full, third word waits for the channel-0 pop
    drive(1'b1, 2'd0, 16'h1000); tick();
    drive(1'b1, 2'd1, 16'h1001); tick();
    drive(1'b1, 2'd3, 16'h1003); tick();
    chk("held_third", 64'(accepted), 64'd0);
    tick();
    chk("still_held", 64'(accepted), 64'd0);
    out_ready = 4'h1;
    n = 0;
    accepted = 1'b0;
    while (!accepted && n < 10) begin
      tick();
      n++;
    end
    chk("third_accepted", 64'(accepted), 64'd1);
    drain();

    // Back-to-back stream across all channels
    out_ready = 4'hF;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, SW'(i % 4), W'($urandom));
      tick();
      chk("stream_acc", 64'(accepted), 64'd1);
    end
    drain();

`ifdef DMUX_STREAM_COUNT_EN
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'd1, W'(16'h2000 + i));
      tick();
    end
    drain();
    chk("cnt1_sat", 64'(count[1*CW +: CW]), 64'd3);
    out_ready = '0;
    drive(1'b1, 2'd1, 16'h2100); tick();
    drive(1'b0, '0, '0);
    out_ready = 4'h2;
    count_clr = 1'b1;
    tick();
    count_clr = 1'b0;
    tick();
    chk("cnt1_clr", 64'(count[1*CW +: CW]), 64'd0);
`endif

    // Discard path on the 3-way instance
    in_valid = 1'b0;
    b_in_valid = 1'b1; b_in_sel = 2'd3; b_in_data = 16'h1234;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    chk("b_drop_hi",    64'(b_drop),      64'd1);
    chk("b_drop_valid", 64'(b_out_valid), 64'd0);
    chk("b_drop_ready", 64'(b_in_ready),  64'd1);
    @(posedge clk); #1;
    chk("b_drop_lo",    64'(b_drop),      64'd0);
    b_in_valid = 1'b1; b_in_sel = 2'd2; b_in_data = 16'h5678;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    @(posedge clk); #1;
    chk("b_after_valid", 64'(b_out_valid), 64'h4);
    chk("b_after_data",  64'(b_out_data),  {16'h0, 16'h5678, 32'h0});
    chk("b_after_ready", 64'(b_in_ready),  64'd1);

    // Asynchronous reset with the FIFO full
    out_ready = '0;
    drive(1'b1, 2'd3, 16'h3003); tick();
    drive(1'b1, 2'd0, 16'h3000); tick();
    drive(1'b0, '0, '0);
    chk("full_before_rst", 64'(in_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_out_data",  64'(out_data),  64'd0);
    chk("arst_in_ready",  64'(in_ready),  64'd1);
    sb.delete();
`ifdef DMUX_STREAM_COUNT_EN
    mcnt = '0;
`endif
    #1 rst_n = 1'b1;
    out_ready = '1;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dmux_stream.md
# dmux_stream

Parametrised, registered successor to the single-bit 1:2 demultiplexer: routes a WIDTH-bit word to one of WAYS output channels selected per word, with valid/ready handshakes on both sides. A 2-entry FIFO decouples the input from the outputs, so a stalled destination never combinationally back-pressures the source. It sits between a single producer and several consumers, for example a CPU data bus fanning out to memory-mapped peripherals.

## Interface
- WIDTH, 16, data bits per word.
- WAYS, 4, number of output channels; must be ≥ 2.
- SEL_W, 2, select width; must satisfy 2^SEL_W ≥ WAYS.
- CNT_W, 16, per-channel counter width (used only with the macro).

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  input word present.
- in_ready  out  1  block can accept a word.
- in_data  in  WIDTH  input word.
- in_sel  in  SEL_W  destination channel for in_data.
- out_valid  out  WAYS  bit k set means channel k holds a word.
- out_ready  in  WAYS  bit k set means consumer k takes the word.
- out_data  out  WAYS*WIDTH  flattened; channel k occupies bits [k*WIDTH +: WIDTH].
- drop  out  1  one-cycle pulse: an accepted word had in_sel ≥ WAYS and was discarded.
- count_clr  in  1  synchronous clear of all counters (macro only).
- count  out  WAYS*CNT_W  flattened per-channel delivered-word counts (macro only).

## Operation
- Storage: 2-entry FIFO of {sel, data} with a 2-bit occupancy counter, a 1-bit write pointer and a 1-bit read pointer.
- in_ready = (occupancy < 2). It depends only on registered state, with no path from out_ready.
- Push: in_valid & in_ready at an edge. If in_sel < WAYS, the word is written. Otherwise it is discarded and drop is high for the next cycle.
- Head (FIFO non-empty): out_valid = one-hot of head sel. The out_data slice for head sel carries head data, and all other slices are 0 (dmux semantics). When the FIFO is empty, out_valid = 0 and out_data = 0.
- Pop: out_valid[k] & out_ready[k] for k = head sel. out_ready bits of non-selected channels are ignored.
- Simultaneous push and pop updates occupancy by +1 − 1, i.e. it stays the same. Pointers wrap modulo 2.
- Words leave in acceptance order, including across channels. A head blocked on channel k stalls all later words (no reordering).
- Reset mid-operation: all stored words are lost, and every output returns to its reset value asynchronously.

## Timing
- Reset values: in_ready = 1, out_valid = 0, out_data = 0, drop = 0, count = 0.
- Latency: a word accepted at edge t into an empty FIFO is visible on out_valid/out_data in the cycle after t.
- Throughput: 1 word/cycle sustained while the head consumer holds out_ready high.
- Full: occupancy 2 forces in_ready = 0. in_ready returns to 1 in the cycle after the first pop.
- Empty with simultaneous push: the word appears only after the edge. There is no combinational bypass.
- out_valid[k], once asserted, stays asserted with stable data until popped or reset.
- drop is registered: high exactly one cycle per discarded word. It does not affect occupancy.

## Configuration
- DMUX_STREAM_COUNT_EN defined:
  - Adds count_clr, count and WAYS counters of CNT_W bits.
  - count[k] increments on each pop from channel k and saturates at 2^CNT_W − 1.
  - count_clr sets all counters to 0 at the edge. If count_clr and a pop coincide, the result is 0 (clear wins).
- Not defined: the count_clr and count ports, and the counters, are absent. All other behaviour is identical.

## Test plan
- Reset, then drive in_data=16'hA5A5, in_sel=2, in_valid for 1 cycle with out_ready=0 → next cycle out_valid=4'b0100, slice 2 = 16'hA5A5, slices 0/1/3 = 0, in_ready=1.
- Hold out_ready=0 and push 3 words (sel 0, 1, 3) → first two accepted; in_ready=0 after the second; third held until out_ready[0]=1 pops word 0, then accepted.
- out_ready=4'hF, stream 8 words with sel 0,1,2,3,0,1,2,3 back-to-back → one word per cycle, in order, each on its channel, in_ready never drops.
- WAYS=3, SEL_W=2: push sel=3 data=16'h1234 → drop=1 for one cycle, out_valid stays 0, occupancy unchanged.
- With the FIFO full, assert rst_n=0 mid-cycle → out_valid=0, out_data=0 and in_ready=1 immediately; after release, no stale word appears.
- With DMUX_STREAM_COUNT_EN and CNT_W=2: pop 5 words on channel 1 → count slice 1 = 3 (saturated); count_clr together with a pop → 0.
